// File: rtl/em_stage_reg_v2_pkg.sv
// em_stage_reg_v2_pkg: shared constants for the EX->MEM pipeline register.
//   EM_TNEW_W    default Tnew counter width
//   EM_RESET_PC  M_PC value after Reset or on a bubble
//   EM_NOP       instruction encoding used for a bubble
package em_stage_reg_v2_pkg;

  localparam int unsigned EM_TNEW_W   = 3;
  localparam logic [31:0] EM_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EM_NOP      = 32'h0000_0000;

endpackage : em_stage_reg_v2_pkg

// File: rtl/em_stage_reg_v2_pipe_field_reg.sv
// pipe_field_reg: one W-bit pipeline field with sync reset, clear and hold.
//   Clk    in   1   clock, rising edge
//   Reset  in   1   synchronous, active-high; loads RST_VAL
//   clr    in   1   bubble insert; loads RST_VAL, overrides hold
//   hold   in   1   keep current contents
//   d      in   W   next value when advancing
//   q      out  W   registered field
module pipe_field_reg #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority: reset/clear > hold > load.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      q <= RST_VAL;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule : pipe_field_reg

// File: rtl/em_stage_reg_v2.sv
// em_stage_reg_v2: EX->MEM pipeline register with stall, flush, valid tracking,
// a self-decrementing Tnew counter and forwarding qualifiers for the M stage.
//   Clk, Reset           clock / synchronous active-high reset
//   Stall, Flush         hold M contents / load a bubble (Flush wins)
//   E_*                  E-stage instruction fields
//   M_*                  registered M-stage fields
//   M_FwdValid/FwdData   forwarding qualifier and value, from registered state only
module em_stage_reg_v2
  import em_stage_reg_v2_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       TNEW_W   = EM_TNEW_W,
  parameter int unsigned       SB_W     = 8,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(EM_RESET_PC)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              E_Valid,
  input  logic              E_WE,
  input  logic [DATA_W-1:0] E_Instr,
  input  logic [DATA_W-1:0] E_PC,
  input  logic [DATA_W-1:0] E_AluC,
  input  logic [DATA_W-1:0] E_Imm32,
  input  logic [DATA_W-1:0] E_RT_Data,
  input  logic [ADDR_W-1:0] E_RegAddr,
  input  logic [TNEW_W-1:0] E_Tnew,
  input  logic [SB_W-1:0]   E_SB,
  output logic              M_Valid,
  output logic              M_WE,
  output logic [DATA_W-1:0] M_Instr,
  output logic [DATA_W-1:0] M_PC,
  output logic [DATA_W-1:0] M_AluC,
  output logic [DATA_W-1:0] M_Imm32,
  output logic [DATA_W-1:0] M_RT_Data,
  output logic [ADDR_W-1:0] M_RegAddr,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic [SB_W-1:0]   M_SB,
  output logic              M_FwdValid,
  output logic [DATA_W-1:0] M_FwdData
);

  // Saturating decrement: a finished result stays finished.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  // Invalid E input must not look like a pending register write.
  logic              we_d;
  logic [ADDR_W-1:0] regaddr_d;
  assign we_d      = E_WE & E_Valid;
  assign regaddr_d = E_Valid ? E_RegAddr : '0;

  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_Valid), .q(M_Valid));

  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_we (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(we_d), .q(M_WE));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(DATA_W'(EM_NOP))) u_instr (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_Instr), .q(M_Instr));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_PC), .q(M_PC));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(DATA_W'(0))) u_aluc (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_AluC), .q(M_AluC));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(DATA_W'(0))) u_imm32 (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_Imm32), .q(M_Imm32));

  pipe_field_reg #(.W(DATA_W), .RST_VAL(DATA_W'(0))) u_rt_data (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_RT_Data), .q(M_RT_Data));

  pipe_field_reg #(.W(ADDR_W), .RST_VAL(ADDR_W'(0))) u_regaddr (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(regaddr_d), .q(M_RegAddr));

  pipe_field_reg #(.W(SB_W), .RST_VAL(SB_W'(0))) u_sb (
    .Clk(Clk), .Reset(Reset), .clr(Flush), .hold(Stall), .d(E_SB), .q(M_SB));

  // Tnew keeps counting down while the instruction is held, since time still passes.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      M_Tnew <= '0;
    end else if (Stall) begin
      M_Tnew <= sat_dec(M_Tnew);
    end else begin
      M_Tnew <= E_Valid ? sat_dec(E_Tnew) : '0;
    end
  end

  // Register $0 is never a forwarding source.
  assign M_FwdValid = M_Valid & M_WE & (M_RegAddr != '0) & (M_Tnew == '0);
  assign M_FwdData  = M_AluC;

endmodule : em_stage_reg_v2
